// File: rtl/spram_arbiter_pkg.sv
// Shared constants and types for the SPRAM bank arbiter.
// Address layout, FSM encodings and bank-select helper.
package spram_arbiter_pkg;

    localparam int BANK_HI = 15;
    localparam int BANK_LO = 14;
    localparam int ROW_W   = 14;
    localparam int NBANK   = 4;
    localparam int IDLE_W  = 16;
    localparam int WCNT_W  = 8;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_WAKE = 1'b1;

    typedef logic [1:0] bank_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    function automatic logic [NBANK-1:0] bank_sel(bank_t b);
        return 4'b0001 << b;
    endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Requester-side handshake bundle for one arbiter port.
// master = requester, slave = arbiter.
interface spram_arbiter_if;

    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [15:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/spram_arbiter_bank_pwr.sv
// Per-bank power control: idle counter, sleep register, wake-done flag.
// Banks come out of reset asleep and wake only on demand.
module spram_arbiter_bank_pwr
    import spram_arbiter_pkg::*;
#(
    parameter int IDLE_SLEEP = 256,
    parameter int WAKE_CYC   = 4
) (
    input  logic clk,
    input  logic resetq,
    input  logic access_i,
    input  logic wake_req_i,
    output logic sleep_o,
    output logic ready_o
);

    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'(IDLE_SLEEP - 1);
    localparam logic [WCNT_W-1:0] WAKE_LAST =
        WCNT_W'(WAKE_CYC - 1);

    logic              sleep_q, sleep_d;
    logic              done_q, done_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;

    always_comb begin
        sleep_d = sleep_q;
        done_d  = done_q;
        idle_d  = idle_q;
        wcnt_d  = wcnt_q;
        if (wake_req_i) begin
            sleep_d = 1'b0;
            done_d  = 1'b0;
            idle_d  = '0;
            wcnt_d  = '0;
        end else if (sleep_q) begin
            idle_d = '0;
        end else if (!done_q) begin
            // settle time before the first access
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WAKE_LAST)
                done_d = 1'b1;
        end else if (access_i) begin
            idle_d = '0;
        end else if (IDLE_SLEEP != 0 &&
                     idle_q == IDLE_LAST) begin
            sleep_d = 1'b1;
            idle_d  = '0;
        end else if (idle_q != '1) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sleep_q <= 1'b1;
            done_q  <= 1'b0;
            idle_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            sleep_q <= sleep_d;
            done_q  <= done_d;
            idle_q  <= idle_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign sleep_o = sleep_q;
    assign ready_o = !sleep_q && done_q;

endmodule

// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter in front of four SB_SPRAM256KA banks.
// One access per cycle; sleeping banks are woken before being granted.
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int IDLE_SLEEP = 256,
    parameter int WAKE_CYC   = 4
) (
    input  logic               clk,
    input  logic               resetq,
    spram_arbiter_if.slave     a,
    spram_arbiter_if.slave     b,
    output logic [ROW_W-1:0]   ram_addr,
    output logic [15:0]        ram_wdata,
    output logic               ram_wren,
    output logic [NBANK-1:0]   ram_cs,
    output logic [NBANK-1:0]   ram_sleep,
    input  logic [63:0]        ram_rdata
);

    localparam logic [WCNT_W-1:0] WAKE_LAST =
        WCNT_W'(WAKE_CYC - 1);

    logic [0:0]        state_q, state_d;
    logic [WCNT_W-1:0] wk_q, wk_d;
    port_e             last_q, last_d;
    logic              rv_a_q, rv_a_d;
    logic              rv_b_q, rv_b_d;
    bank_t             rbank_q, rbank_d;
    logic [15:0]       hold_a_q, hold_a_d;
    logic [15:0]       hold_b_q, hold_b_d;

    logic [NBANK-1:0]  bank_rdy;
    logic              any_req;
    port_e             cand;
    acc_t              acc_a, acc_b, c_acc;
    bank_t             c_bank;
    logic              grant;
    logic              wake;
    logic [15:0]       rd_slice;

    assign acc_a = '{a.we, a.addr, a.wdata};
    assign acc_b = '{b.we, b.addr, b.wdata};

    // both requesting: the one not granted last goes first
    always_comb begin
        any_req = a.req | b.req;
        cand    = PORT_A;
        unique case (1'b1)
            a.req & b.req:
                cand = (last_q == PORT_A) ? PORT_B : PORT_A;
            b.req & ~a.req:
                cand = PORT_B;
            default:
                cand = PORT_A;
        endcase
    end

    assign c_acc  = (cand == PORT_A) ? acc_a : acc_b;
    assign c_bank = c_acc.addr[BANK_HI:BANK_LO];

    assign grant = (state_q == ST_ARB) && any_req &&
                   bank_rdy[c_bank];
    assign wake  = (state_q == ST_ARB) && any_req &&
                   !bank_rdy[c_bank];

    assign a.gnt = grant && (cand == PORT_A);
    assign b.gnt = grant && (cand == PORT_B);

    assign ram_cs    = grant ? bank_sel(c_bank) : '0;
    assign ram_wren  = grant && c_acc.we;
    assign ram_addr  = grant ? c_acc.addr[ROW_W-1:0] : '0;
    assign ram_wdata = grant ? c_acc.wdata : '0;

    for (genvar g = 0; g < NBANK; g++) begin : g_pwr
        spram_arbiter_bank_pwr #(
            .IDLE_SLEEP (IDLE_SLEEP),
            .WAKE_CYC   (WAKE_CYC)
        ) u_pwr (
            .clk        (clk),
            .resetq     (resetq),
            .access_i   (ram_cs[g]),
            .wake_req_i (wake && (c_bank == 2'(g))),
            .sleep_o    (ram_sleep[g]),
            .ready_o    (bank_rdy[g])
        );
    end

    // rr pointer is left alone in WAKE so the woken requester wins next
    always_comb begin
        state_d = state_q;
        wk_d    = wk_q;
        last_d  = last_q;
        unique case (state_q)
            ST_WAKE: begin
                if (wk_q == WAKE_LAST)
                    state_d = ST_ARB;
                else
                    wk_d = wk_q + 1'b1;
            end
            default: begin
                if (grant)
                    last_d = cand;
                if (wake) begin
                    state_d = ST_WAKE;
                    wk_d    = '0;
                end
            end
        endcase
    end

    assign rd_slice = ram_rdata[{rbank_q, 4'b0000} +: 16];

    assign a.rvalid = rv_a_q;
    assign b.rvalid = rv_b_q;
    assign a.rdata  = rv_a_q ? rd_slice : hold_a_q;
    assign b.rdata  = rv_b_q ? rd_slice : hold_b_q;

    always_comb begin
        rv_a_d   = a.gnt && !a.we;
        rv_b_d   = b.gnt && !b.we;
        rbank_d  = grant ? c_bank : rbank_q;
        hold_a_d = a.rdata;
        hold_b_d = b.rdata;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q  <= ST_ARB;
            wk_q     <= '0;
            last_q   <= PORT_A;
            rv_a_q   <= 1'b0;
            rv_b_q   <= 1'b0;
            rbank_q  <= '0;
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else begin
            state_q  <= state_d;
            wk_q     <= wk_d;
            last_q   <= last_d;
            rv_a_q   <= rv_a_d;
            rv_b_q   <= rv_b_d;
            rbank_q  <= rbank_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Randomized bench for spram_arbiter with a cycle-level reference
// model of arbitration, bank power and read return.
module tb_spram_arbiter;

    localparam int IDLE_SLEEP = 24;
    localparam int WAKE_CYC   = 4;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic [13:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_wren;
    logic [3:0]  ram_cs;
    logic [3:0]  ram_sleep;
    logic [63:0] ram_rdata;

    always #5 clk = ~clk;

    spram_arbiter_if a_if ();
    spram_arbiter_if b_if ();

    spram_arbiter #(
        .IDLE_SLEEP (IDLE_SLEEP),
        .WAKE_CYC   (WAKE_CYC)
    ) dut (
        .clk       (clk),
        .resetq    (resetq),
        .a         (a_if),
        .b         (b_if),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wren  (ram_wren),
        .ram_cs    (ram_cs),
        .ram_sleep (ram_sleep),
        .ram_rdata (ram_rdata)
    );

    // behavioural SPRAM banks
    logic [15:0] mem [4][16384] = '{default: '0};
    logic [15:0] dout [4] = '{default: '0};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_cs[k] && !ram_sleep[k]) begin
                if (ram_wren)
                    mem[k][ram_addr] <= ram_wdata;
                else
                    dout[k] <= mem[k][ram_addr];
            end
        end
    end

    assign ram_rdata = {dout[3], dout[2], dout[1], dout[0]};

    a_hold: assert property (@(posedge clk) disable iff (!resetq)
        a_if.req && !a_if.gnt |=> a_if.req)
        else $error("port A dropped req before gnt");
    b_hold: assert property (@(posedge clk) disable iff (!resetq)
        b_if.req && !b_if.gnt |=> b_if.req)
        else $error("port B dropped req before gnt");

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h",
                     tag, got, exp);
        end
    endtask

    // reference model state
    bit          m_asleep [4];
    int          m_idle [4];
    int          m_warm [4];
    int          m_wake;
    int          m_last;
    bit          m_prv [2];
    logic [15:0] m_pdata [2];
    logic [15:0] m_hold [2];
    logic [15:0] m_mem [int];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_asleep[k] = 1'b1;
            m_idle[k]   = 0;
            m_warm[k]   = 0;
        end
        m_wake = 0;
        m_last = 0;
        for (int p = 0; p < 2; p++) begin
            m_prv[p]   = 1'b0;
            m_pdata[p] = '0;
            m_hold[p]  = '0;
        end
    endtask

    task automatic model_cycle();
        bit          rq [2];
        bit          we [2];
        logic [15:0] ad [2];
        logic [15:0] wd [2];
        bit          g [2];
        bit          acc [4];
        logic [3:0]  e_sleep;
        logic [3:0]  e_cs;
        int          win;
        int          wb;
        int          cand;
        int          bk;
        rq[0] = a_if.req; we[0] = a_if.we;
        ad[0] = a_if.addr; wd[0] = a_if.wdata;
        rq[1] = b_if.req; we[1] = b_if.we;
        ad[1] = b_if.addr; wd[1] = b_if.wdata;
        g = '{0, 0};
        acc = '{default: 0};
        win = -1; wb = -1; bk = 0; e_cs = '0;

        if (m_prv[0]) m_hold[0] = m_pdata[0];
        if (m_prv[1]) m_hold[1] = m_pdata[1];
        chk("a_rvalid", 32'(a_if.rvalid), 32'(m_prv[0]));
        chk("b_rvalid", 32'(b_if.rvalid), 32'(m_prv[1]));
        chk("a_rdata", 32'(a_if.rdata), 32'(m_hold[0]));
        chk("b_rdata", 32'(b_if.rdata), 32'(m_hold[1]));
        for (int k = 0; k < 4; k++) e_sleep[k] = m_asleep[k];
        chk("ram_sleep", 32'(ram_sleep), 32'(e_sleep));

        if (m_wake > 0) begin
            m_wake--;
        end else if (rq[0] || rq[1]) begin
            if (rq[0] && rq[1]) cand = (m_last == 0) ? 1 : 0;
            else                cand = rq[0] ? 0 : 1;
            bk = int'(ad[cand][15:14]);
            if (!m_asleep[bk] && m_warm[bk] == 0) begin
                win = cand;
                g[cand] = 1'b1;
                m_last = cand;
                acc[bk] = 1'b1;
                e_cs = 4'b0001 << bk;
            end else begin
                wb = bk;
            end
        end

        chk("a_gnt", 32'(a_if.gnt), 32'(g[0]));
        chk("b_gnt", 32'(b_if.gnt), 32'(g[1]));
        chk("ram_cs", 32'(ram_cs), 32'(e_cs));
        chk("ram_wren", 32'(ram_wren),
            32'(win >= 0 && we[win < 0 ? 0 : win]));
        if (win >= 0) begin
            chk("ram_addr", 32'(ram_addr), 32'(ad[win][13:0]));
            if (we[win])
                chk("ram_wdata", 32'(ram_wdata), 32'(wd[win]));
        end

        for (int p = 0; p < 2; p++) begin
            m_prv[p] = g[p] && !we[p];
            if (m_prv[p])
                m_pdata[p] = m_mem.exists(int'(ad[p])) ?
                             m_mem[int'(ad[p])] : 16'h0;
        end
        if (win >= 0 && we[win]) m_mem[int'(ad[win])] = wd[win];

        for (int k = 0; k < 4; k++) begin
            if (m_asleep[k]) begin
                m_idle[k] = 0;
            end else if (m_warm[k] > 0) begin
                m_warm[k]--;
            end else if (acc[k]) begin
                m_idle[k] = 0;
            end else if (m_idle[k] == IDLE_SLEEP - 1) begin
                m_asleep[k] = 1'b1;
                m_idle[k]   = 0;
            end else begin
                m_idle[k]++;
            end
        end
        if (wb >= 0) begin
            m_asleep[wb] = 1'b0;
            m_warm[wb]   = WAKE_CYC;
            m_idle[wb]   = 0;
            m_wake       = WAKE_CYC;
        end
    endtask

    // requester drivers
    bit          pend [2];
    bit          p_we [2];
    logic [15:0] p_addr [2];
    logic [15:0] p_wd [2];
    int          gen_rate [2];
    int          gen_we [2];
    int          gen_bank [2];

    bit          obs_gnt [2];
    bit          obs_rv [2];
    logic [15:0] obs_rd [2];
    logic [3:0]  obs_cs;
    logic [3:0]  obs_sleep;

    task automatic apply(input int p);
        if (p == 0) begin
            a_if.req = pend[0]; a_if.we = p_we[0];
            a_if.addr = p_addr[0]; a_if.wdata = p_wd[0];
        end else begin
            b_if.req = pend[1]; b_if.we = p_we[1];
            b_if.addr = p_addr[1]; b_if.wdata = p_wd[1];
        end
    endtask

    task automatic req(input int p, input bit we,
                       input logic [15:0] ad,
                       input logic [15:0] wd);
        pend[p] = 1'b1; p_we[p] = we;
        p_addr[p] = ad; p_wd[p] = wd;
        apply(p);
    endtask

    task automatic drive_port(input int p);
        int bk;
        if (obs_gnt[p]) pend[p] = 1'b0;
        if (!pend[p] && gen_rate[p] > 0 &&
            $urandom_range(1, 100) <= gen_rate[p]) begin
            pend[p] = 1'b1;
            p_we[p] = (gen_we[p] == 2) ?
                      1'($urandom_range(0, 1)) : 1'(gen_we[p]);
            bk = (gen_bank[p] < 0) ?
                 int'($urandom_range(0, 3)) : gen_bank[p];
            p_addr[p] = {2'(bk), 14'($urandom_range(0, 15))};
            p_wd[p] = 16'($urandom);
        end
        apply(p);
    endtask

    task automatic step();
        @(negedge clk);
        if (resetq) model_cycle();
        obs_gnt[0] = a_if.gnt;   obs_gnt[1] = b_if.gnt;
        obs_rv[0]  = a_if.rvalid; obs_rv[1] = b_if.rvalid;
        obs_rd[0]  = a_if.rdata; obs_rd[1]  = b_if.rdata;
        obs_cs     = ram_cs;
        obs_sleep  = ram_sleep;
        @(posedge clk);
        #1;
        drive_port(0);
        drive_port(1);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_gnt(input int p, output int n,
                            output int n_other);
        n = 0;
        n_other = 0;
        do begin
            step();
            n++;
            if (!obs_gnt[p] && obs_gnt[1-p]) n_other++;
        end while (!obs_gnt[p] && n < 40);
    endtask

    task automatic drain();
        int k = 0;
        gen_rate = '{0, 0};
        while ((pend[0] || pend[1]) && k < 60) begin
            step();
            k++;
        end
        chk("drain", 32'(pend[0] | pend[1]), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int nb;
        int cnt;
        bit pa;
        bit pb;
        pend = '{0, 0}; p_we = '{0, 0};
        p_addr = '{16'h0, 16'h0}; p_wd = '{16'h0, 16'h0};
        gen_rate = '{0, 0}; gen_we = '{0, 0};
        gen_bank = '{-1, -1};
        obs_gnt = '{0, 0};
        apply(0);
        apply(1);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sleep", 32'(ram_sleep), 32'hF);
        chk("rst_cs", 32'(ram_cs), 32'h0);
        chk("rst_wren", 32'(ram_wren), 32'h0);
        chk("rst_rvalid", 32'({a_if.rvalid, b_if.rvalid}), 32'h0);
        chk("rst_rdata", 32'(a_if.rdata), 32'h0);
        resetq = 1'b1;

        // write then read through a sleeping bank
        req(0, 1'b1, 16'h4005, 16'h1234);
        wait_gnt(0, n, nb);
        chk("t1_wake_lat", 32'(n), 32'(WAKE_CYC + 2));
        chk("t1_cs", 32'(obs_cs), 32'b0010);
        req(0, 1'b0, 16'h4005, 16'h0);
        wait_gnt(0, n, nb);
        chk("t1_rd_lat", 32'(n), 32'd1);
        step();
        chk("t1_rvalid", 32'(obs_rv[0]), 32'd1);
        chk("t1_rdata", 32'(obs_rd[0]), 32'h1234);

        // A on bank 0, B on bank 2, continuous
        gen_rate = '{100, 100}; gen_we = '{1, 1};
        gen_bank = '{0, 2};
        run(40);
        gen_we = '{0, 0};
        run(20);
        step();
        pa = obs_gnt[0]; pb = obs_gnt[1];
        chk("t2_onehot", 32'(pa ^ pb), 32'd1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t2_alt", 32'({obs_gnt[0], obs_gnt[1]}),
                32'({pb, pa}));
            pa = obs_gnt[0]; pb = obs_gnt[1];
        end
        drain();
        gen_bank = '{-1, -1};

        // bank 3 idles into sleep while B keeps bank 0 busy
        req(0, 1'b1, 16'hC000, 16'h5A5A);
        wait_gnt(0, n, nb);
        chk("t3_first", 32'(n), 32'(WAKE_CYC + 2));
        gen_rate = '{0, 100}; gen_we = '{0, 0};
        gen_bank = '{-1, 0};
        run(IDLE_SLEEP + 10);
        chk("t3_sleep3", 32'(obs_sleep[3]), 32'd1);
        chk("t3_awake0", 32'(obs_sleep[0]), 32'd0);
        req(0, 1'b0, 16'hC000, 16'h0);
        wait_gnt(0, n, nb);
        chk("t3_wake_lat", 32'(n), 32'(WAKE_CYC + 2));
        chk("t3_b_in_wake", 32'(nb), 32'd0);
        step();
        chk("t3_rdata", 32'(obs_rd[0]), 32'h5A5A);
        drain();
        gen_bank = '{-1, -1};

        // write on A, read same address on B next cycle
        req(0, 1'b1, 16'h0010, 16'hBEEF);
        wait_gnt(0, n, nb);
        chk("t4_a_lat", 32'(n), 32'd1);
        req(1, 1'b0, 16'h0010, 16'h0);
        wait_gnt(1, n, nb);
        chk("t4_b_lat", 32'(n), 32'd1);
        step();
        chk("t4_rvalid", 32'(obs_rv[1]), 32'd1);
        chk("t4_rdata", 32'(obs_rd[1]), 32'hBEEF);

        // reset right after a read grant
        req(1, 1'b0, 16'h0010, 16'h0);
        wait_gnt(1, n, nb);
        chk("t5_lat", 32'(n), 32'd1);
        req(1, 1'b0, 16'h0011, 16'h0);
        resetq = 1'b0;
        #1;
        chk("t5_rvalid", 32'({a_if.rvalid, b_if.rvalid}), 32'h0);
        chk("t5_sleep", 32'(ram_sleep), 32'hF);
        chk("t5_gnt", 32'({a_if.gnt, b_if.gnt}), 32'h0);
        chk("t5_cs", 32'(ram_cs), 32'h0);
        chk("t5_rdata", 32'(b_if.rdata), 32'h0);
        model_reset();
        pend = '{0, 0};
        obs_gnt = '{0, 0};
        apply(0);
        apply(1);
        @(posedge clk);
        #1;
        resetq = 1'b1;

        // B streams reads alone
        gen_rate = '{0, 100}; gen_we = '{0, 0};
        gen_bank = '{-1, 1};
        run(12);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (obs_gnt[1]) cnt++;
        end
        chk("t6_thru", 32'(cnt), 32'd16);
        drain();
        gen_bank = '{-1, -1};

        // random traffic phases
        gen_we = '{2, 2};
        gen_rate = '{80, 80};  run(600);
        gen_rate = '{30, 70};  run(600);
        gen_rate = '{10, 10};  run(600);
        gen_rate = '{100, 5};  run(600);
        drain();
        run(IDLE_SLEEP + 10);
        chk("end_sleep", 32'(obs_sleep), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
